fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 148 ++++++++++++++
 tb/tb_fetch_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues 16-bit program-memory fetches and buffers them in a prefetch queue.
// Optional build macro FETCH_PERF_CNT_EN adds saturating pop/redirect performance counters.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [12:0] RESET_PC = 13'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [12:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [12:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [15:0] inst_data,
  output logic [12:0] inst_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] perf_fetch_cnt,
  output logic [15:0] perf_flush_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] ST_START = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [12:0]   r_fetch_pc;
  logic [12:0]   r_rsp_pc;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [15:0]   r_mem_data [DEPTH];
  logic [12:0]   r_mem_pc   [DEPTH];

  logic w_accept;
  logic w_rsp;
  logic w_push;
  logic w_pop;
  logic w_nonempty;

  // A response only counts if a request is actually outstanding; strays are dropped.
  assign w_rsp      = imem_rvalid && (r_out != '0);
  assign w_push     = w_rsp && (r_state == ST_RUN) && !redirect_valid;
  assign w_nonempty = (r_count != '0);

  assign imem_req   = (r_state != ST_START) && !redirect_valid &&
                      ((int'(r_count) + int'(r_out)) < DEPTH);
  assign imem_addr  = r_fetch_pc;
  assign w_accept   = imem_req && imem_gnt;

  assign inst_valid = w_nonempty && !redirect_valid;
  assign inst_data  = w_nonempty ? r_mem_data[r_rptr] : '0;
  assign inst_pc    = w_nonempty ? r_mem_pc[r_rptr]   : '0;
  assign w_pop      = inst_valid && inst_ready;

  // NOTE: default assignment first so every path drives w_state_nxt (no latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_START:          w_state_nxt = ST_RUN;
      ST_RUN, ST_FLUSH:  w_state_nxt = redirect_valid ? ST_FLUSH : ST_RUN;
      default:           w_state_nxt = ST_START;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_START;
      r_fetch_pc <= {RESET_PC[12:1], 1'b0};
      r_rsp_pc   <= '0;
      r_out      <= '0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (redirect_valid)
        r_fetch_pc <= {redirect_pc[12:1], 1'b0};
      else if (w_accept)
        r_fetch_pc <= r_fetch_pc + 13'd2;

      // Memory latency is exactly one cycle, so one address register tracks the in-flight fetch.
      if (w_accept)
        r_rsp_pc <= r_fetch_pc;

      case ({w_accept, w_rsp})
        2'b10:   r_out <= r_out + CW'(1);
        2'b01:   r_out <= r_out - CW'(1);
        default: r_out <= r_out;
      endcase

      if (redirect_valid) begin
        r_count <= '0;
        r_wptr  <= '0;
        r_rptr  <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + AW'(1);
        if (w_pop)  r_rptr <= r_rptr + AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // NOTE: queue storage is deliberately not reset; occupancy gates every read of it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wptr] <= imem_rdata;
      r_mem_pc[r_wptr]   <= r_rsp_pc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_perf_fetch;
  logic [15:0] r_perf_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetch <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_pop && (r_perf_fetch != 16'hFFFF))
        r_perf_fetch <= r_perf_fetch + 16'd1;
      if (redirect_valid && (r_perf_flush != 16'hFFFF))
        r_perf_flush <= r_perf_flush + 16'd1;
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_flush_cnt = r_perf_flush;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: default instance plus a RESET_PC=0x1FFC instance for address wrap.
// Both share control stimulus; each has a memory model that returns the address as data.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      = 1'b1;
  logic        gnt      = 1'b1;
  logic        ready    = 1'b1;
  logic        redir_v  = 1'b0;
  logic [12:0] redir_pc = '0;

  logic        req_a, rvalid_a = 1'b0, ivalid_a;
  logic [12:0] addr_a, ipc_a;
  logic [15:0] rdata_a = '0, idata_a;

  logic        req_b, rvalid_b = 1'b0, ivalid_b;
  logic [12:0] addr_b, ipc_b;
  logic [15:0] rdata_b = '0, idata_b;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] pf_a, pl_a, pf_b, pl_b;
`endif

  int n_checks = 0;
  int n_errors = 0;

  fetch_unit #(.DEPTH(4)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req(req_a), .imem_addr(addr_a), .imem_gnt(gnt),
    .imem_rvalid(rvalid_a), .imem_rdata(rdata_a),
    .redirect_valid(redir_v), .redirect_pc(redir_pc),
    .inst_valid(ivalid_a), .inst_ready(ready), .inst_data(idata_a), .inst_pc(ipc_a)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(pf_a), .perf_flush_cnt(pl_a)
`endif
  );

  fetch_unit #(.DEPTH(4), .RESET_PC(13'h1FFC)) u_dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req(req_b), .imem_addr(addr_b), .imem_gnt(gnt),
    .imem_rvalid(rvalid_b), .imem_rdata(rdata_b),
    .redirect_valid(redir_v), .redirect_pc(redir_pc),
    .inst_valid(ivalid_b), .inst_ready(ready), .inst_data(idata_b), .inst_pc(ipc_b)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(pf_b), .perf_flush_cnt(pl_b)
`endif
  );

  // Program memory: one-cycle read latency, data equals the requested address.
  always @(posedge clk) begin
    rvalid_a <= req_a && gnt;
    rdata_a  <= {3'b000, addr_a};
    rvalid_b <= req_b && gnt;
    rdata_b  <= {3'b000, addr_b};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Two reset edges, then return at the negedge of the first post-release cycle (START).
  task automatic reset_seq();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc;
    logic [12:0] exp_b;

    // Reset state and first fetches.
    @(negedge clk); #1;
    check("rst_req",   req_a,    0);
    check("rst_valid", ivalid_a, 0);
    check("rst_data",  idata_a,  0);
    check("rst_pc",    ipc_a,    0);
    @(negedge clk); rst = 1'b0; #1;
    check("start_req", req_a, 0);
    @(negedge clk); #1;
    check("first_req",   req_a,  1);
    check("first_addr",  addr_a, 13'h0000);
    check("wrap_addr",   addr_b, 13'h1FFC);
    @(negedge clk); #1;
    check("latency_valid", ivalid_a, 0);
    exp_b = 13'h1FFC;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("seq_valid", ivalid_a, 1);
      check("seq_pc",    ipc_a,    13'(2 * i));
      check("seq_data",  idata_a,  16'(2 * i));
      check("wrap_pc",   ipc_b,    exp_b);
      exp_b = exp_b + 13'd2;
    end

    // Back-pressure: queue fills to DEPTH then drains in order.
    ready = 1'b0;
    reset_seq();
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (req_a) acc++;
      @(negedge clk);
    end
    #1;
    check("full_accepts", acc,      4);
    check("full_req",     req_a,    0);
    check("hold_valid",   ivalid_a, 1);
    check("hold_pc",      ipc_a,    13'h0000);
    ready = 1'b1; #1;
    check("drain_pc0", ipc_a, 13'h0000);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk); #1;
      check("drain_valid", ivalid_a, 1);
      check("drain_pc",    ipc_a,    13'(2 * i));
      check("drain_data",  idata_a,  16'(2 * i));
      if (i == 1) check("resume_req", req_a, 1);
    end

    // Redirect with one response in flight and a push/pop in the same cycle.
    reset_seq();
    repeat (4) @(negedge clk);
    redir_v = 1'b1; redir_pc = 13'h0101; #1;
    check("redir_valid", ivalid_a, 0);
    check("redir_req",   req_a,    0);
    @(negedge clk); redir_v = 1'b0; #1;
    check("flush_valid", ivalid_a, 0);
    check("flush_req",   req_a,    1);
    check("flush_addr",  addr_a,   13'h0100);
`ifdef FETCH_PERF_CNT_EN
    check("perf_flush", pl_a, 1);
`endif
    @(negedge clk); #1;
    check("stale_valid", ivalid_a, 0);
    @(negedge clk); #1;
    check("redir_new_valid", ivalid_a, 1);
    check("redir_new_pc",    ipc_a,    13'h0100);
    check("redir_new_data",  idata_a,  16'h0100);
    @(negedge clk); #1;
    check("redir_next_pc", ipc_a, 13'h0102);

    // Reset one cycle after acceptance: late response must be ignored.
    reset_seq();
    @(negedge clk); #1;
    check("pre_rst_req", req_a, 1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    check("abort_valid", ivalid_a, 0);
    check("abort_req",   req_a,    0);
`ifdef FETCH_PERF_CNT_EN
    check("abort_perf_fetch", pf_a, 0);
    check("abort_perf_flush", pl_a, 0);
`endif
    @(negedge clk); #1;
    check("restart_valid", ivalid_a, 0);
    check("restart_addr",  addr_a,   13'h0000);
    @(negedge clk); #1;
    check("restart_lat", ivalid_a, 0);
    @(negedge clk); #1;
    check("restart_deliver", ivalid_a, 1);
    check("restart_pc",      ipc_a,    13'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
